// File: rtl/freq_display_if.sv
// Port bundle between the frequency meter result and the display stage.
// The slave side is the display block; the master side feeds data_fx.
interface freq_display_if;
    logic [19:0] data_fx;
    logic [23:0] bcd_out;
    logic        ovf;
    logic        conv_done;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;

    modport master (
        output data_fx,
        input  bcd_out, ovf, conv_done, seg_sel, seg_led
    );

    modport slave (
        input  data_fx,
        output bcd_out, ovf, conv_done, seg_sel, seg_led
    );
endinterface

// File: rtl/freq_display.sv
// Frequency display stage: periodic sample, shift-and-add-3 BCD conversion,
// saturation at 999 999 and a six-digit multiplexed seven-segment driver.
module freq_display #(
    parameter logic [25:0] CLK_FS     = 26'd50_000_000,
    parameter logic [15:0] SCAN_DIV   = 16'd50_000,
    parameter logic [25:0] UPDATE_DIV = 26'd25_000_000
) (
    input  logic         clk_fs,
    input  logic         rst_n,
    freq_display_if.slave io
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [19:0] BIN_MAX = 20'd999_999;

    state_e      state_q;
    logic [25:0] upd_cnt_q;
    logic [15:0] scan_cnt_q;
    logic [2:0]  dig_q;
    logic [19:0] bin_q;
    logic [23:0] acc_q;
    logic [4:0]  sh_cnt_q;
    logic        ovf_nxt_q;
    logic [23:0] bcd_q;
    logic        ovf_q;
    logic        done_q;
    logic [5:0]  sel_q;
    logic [7:0]  led_q;

    logic        tick_d;
    logic        scan_wrap_d;
    logic [23:0] acc_adj_d;
    logic [5:0]  blank_d;
    logic        run_d;
    logic [3:0]  nib_d;
    logic [5:0]  sel_d;
    logic [7:0]  led_d;

    // Reference clock rate is informational only.
    logic unused_clk_fs;
    assign unused_clk_fs = ^CLK_FS;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick_d      = (upd_cnt_q == UPDATE_DIV - 26'd1);
    assign scan_wrap_d = (scan_cnt_q == SCAN_DIV - 16'd1);

    always_comb begin
        acc_adj_d = acc_q;
        for (int k = 0; k < 6; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj_d[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Digit k blanks only when it and every more significant digit are zero.
    always_comb begin
        run_d   = 1'b1;
        blank_d = '0;
        for (int k = 5; k >= 1; k--) begin
            run_d      = run_d & (bcd_q[4*k +: 4] == 4'd0);
            blank_d[k] = run_d;
        end
    end

    always_comb begin
        sel_d = ~(6'b000001 << dig_q);
        nib_d = 4'(bcd_q >> {dig_q, 2'b00});
        led_d = (|(blank_d & ~sel_d)) ? 8'hFF : seg7(nib_d);
        if (ovf_q && dig_q == 3'd0) begin
            led_d[7] = 1'b0;
        end
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            upd_cnt_q  <= '0;
            scan_cnt_q <= '0;
            dig_q      <= '0;
            sel_q      <= '1;
            led_q      <= '1;
        end else begin
            upd_cnt_q <= tick_d ? '0 : upd_cnt_q + 26'd1;
            if (scan_wrap_d) begin
                scan_cnt_q <= '0;
                dig_q      <= (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 16'd1;
            end
            sel_q <= sel_d;
            led_q <= led_d;
        end
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            sh_cnt_q  <= '0;
            ovf_nxt_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tick_d) begin
                        if (io.data_fx > BIN_MAX) begin
                            bin_q     <= BIN_MAX;
                            ovf_nxt_q <= 1'b1;
                        end else begin
                            bin_q     <= io.data_fx;
                            ovf_nxt_q <= 1'b0;
                        end
                        acc_q    <= '0;
                        sh_cnt_q <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q    <= {acc_adj_d[22:0], bin_q[19]};
                    bin_q    <= {bin_q[18:0], 1'b0};
                    sh_cnt_q <= sh_cnt_q + 5'd1;
                    if (sh_cnt_q == 5'd19) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= acc_q;
                    ovf_q   <= ovf_nxt_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.bcd_out   = bcd_q;
    assign io.ovf       = ovf_q;
    assign io.conv_done = done_q;
    assign io.seg_sel   = sel_q;
    assign io.seg_led   = led_q;
endmodule

// File: doc/freq_display.md
# freq_display

Display stage directly downstream of the frequency meter. Periodically samples the meter's 20-bit frequency result, converts it to six BCD digits with a sequential shift-and-add-3 engine, saturates values above 999 999, and drives a six-digit multiplexed common-anode seven-segment display with leading-zero blanking. The block runs entirely in the meter's reference clock domain, where the frequency result is produced.

## Interface
- CLK_FS, 26'd50_000_000, reference clock frequency in Hz (documentation only; not used in arithmetic)
- SCAN_DIV, 16'd50_000, clk_fs cycles per digit scan slot (1 ms at 50 MHz); must be ≥ 2
- UPDATE_DIV, 26'd25_000_000, clk_fs cycles between samples (0.5 s); must be ≥ 32

- clk_fs  input  1  reference clock; all logic on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- data_fx  input  20  measured frequency in Hz, from the meter
- bcd_out  output  24  displayed value, 6 BCD digits, [3:0] = units
- ovf  output  1  high when the last sample exceeded 999 999
- conv_done  output  1  one-cycle pulse when bcd_out and ovf update
- seg_sel  output  6  digit select, active-low, bit 0 = units digit
- seg_led  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Update counter: counts 0..UPDATE_DIV-1 and wraps. Tick when count == UPDATE_DIV-1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on a tick edge, capture data_fx.
  - If data_fx > 999 999: load 20'd999_999 and set ovf_next=1; otherwise load data_fx and set ovf_next=0.
  - Clear the 24-bit BCD accumulator and the shift counter, then go to SHIFT.
- SHIFT: one iteration per cycle.
  - Add 3 to each BCD nibble ≥ 5.
  - Shift {bcd, bin} left by 1, feeding the binary MSB into the BCD LSB.
  - After the 20th iteration (shift counter == 19), go to DONE.
- DONE: bcd_out ← accumulator, ovf ← ovf_next, conv_done = 1 for this cycle; go to IDLE.
- Ticks arriving outside IDLE are ignored. The UPDATE_DIV constraint prevents this in practice.
- Scan: scan counter 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→…→5→0.
- Blanking: digit k (1..5) is blank when bcd_out digits k..5 are all zero. Digit 0 is never blanked.
- Segment codes (active-low, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- Overflow marker: when ovf=1, the digit-0 slot clears bit 7 (dp lit), so that slot reads code & 8'h7F.
- Arithmetic: the conversion operates on a 20-bit value. The saturated maximum 999 999 fits exactly in 24 bits of BCD. Out-of-range nibbles (>9) never reach the decoder and, if they do, decode to blank.

## Timing
- Reset values:
  - bcd_out 24'h000000, ovf 0, conv_done 0
  - seg_sel 6'b111111, seg_led 8'hFF
  - FSM in IDLE; update, scan and shift counters 0; digit index 0
- Latency: capture edge E0, shift edges E1..E20, DONE edge E21. bcd_out, ovf and conv_done are valid after E21. conv_done falls after E22.
- seg_sel/seg_led are registered and reflect the current digit index and bcd_out one cycle after either changes. Exactly one seg_sel bit is low at any time after the first post-reset edge.
- First tick occurs UPDATE_DIV cycles after reset release. Until then the display shows "0" (digit 0 = C0, others FF).
- Reset mid-conversion: asynchronous return to reset values; the partial result is discarded; conversion restarts on the next tick.
- data_fx is sampled only at the capture edge. Changes during SHIFT/DONE do not affect the result.
- data_fx comes from the same clk_fs domain; no synchroniser is required.

## Test plan
Bench parameters: SCAN_DIV=4, UPDATE_DIV=64.
- data_fx=0 → after conv_done: bcd_out 24'h000000, ovf 0; digit 0 shows C0, digits 1-5 show FF.
- data_fx=123456 → bcd_out 24'h123456, conv_done exactly 21 cycles after the capture edge; scan shows digits 5..0 as F9, A4, B0, 99, 92, 82.
- data_fx=1000 → bcd_out 24'h001000; digits 5 and 4 FF, digit 3 F9, digits 2..0 C0 (interior zeros not blanked).
- data_fx=20'hFFFFF (1 048 575) → bcd_out 24'h999999, ovf 1; digit-0 slot shows 8'h10; next sample of 500 → bcd_out 24'h000500, ovf 0.
- Change data_fx from 42 to 777 on shift cycle 5 → bcd_out 24'h000042; the following tick yields 24'h000777.
- Assert rst_n low at shift cycle 10 → all outputs at reset values immediately; after release, the next conversion completes normally with no conv_done from the aborted one.
